// File: rtl/w450_mem.sv
// Memory responder for the w450 processor: 2**N x N array, two combinational read
// ports, one processor write port and a valid/ready byte-stream program loader.
// Optional same-cycle write-to-read bypass: define W450_MEM_WR_BYPASS_EN.
module w450_mem #(
    parameter int N         = 8,
    parameter bit BOOT_HOLD = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] mem_wr_data,
    input  logic [N-1:0] mem_wr_addr,
    input  logic         mem_wr_en,
    input  logic [N-1:0] mem_rd_addr1,
    output logic [N-1:0] mem_rd_data1,
    input  logic [N-1:0] mem_rd_addr2,
    output logic [N-1:0] mem_rd_data2,
    input  logic         ld_start,
    input  logic [N-1:0] ld_base,
    input  logic [N-1:0] ld_len,
    input  logic [N-1:0] ld_data,
    input  logic         ld_valid,
    output logic         ld_ready,
    output logic         ld_busy,
    output logic         ld_done,
    output logic         cpu_reset
);

    localparam logic [N-1:0] ONE_C = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       state_r;
    state_t       state_next_s;
    logic [N-1:0] addr_r;
    logic [N-1:0] cnt_r;
    logic         cpu_reset_r;
    logic [N-1:0] mem_r [0:(2**N)-1];

    logic         accept_s;
    logic         wr_en_s;
    logic [N-1:0] wr_addr_s;
    logic [N-1:0] wr_data_s;

    // Single array write port shared by processor (idle only) and loader; no writes under reset
    always_comb begin
        accept_s  = 1'b0;
        wr_en_s   = 1'b0;
        wr_addr_s = mem_wr_addr;
        wr_data_s = mem_wr_data;
        if (reset) begin
            accept_s = 1'b0;
            wr_en_s  = 1'b0;
        end else if (state_r == ST_LOAD) begin
            accept_s  = ld_valid;
            wr_en_s   = ld_valid;
            wr_addr_s = addr_r;
            wr_data_s = ld_data;
        end else if (state_r == ST_IDLE) begin
            wr_en_s = mem_wr_en;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Loader next-state decode; the accept that takes cnt from 1 to 0 ends the load
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ld_start) state_next_s = ST_LOAD;
                else          state_next_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (accept_s && (cnt_r == ONE_C)) state_next_s = ST_DONE;
                else                              state_next_s = ST_LOAD;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_next_s;
    end

    // Load pointer/count and processor reset hold; cnt=0 at start wraps so 2**N bytes load
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r      <= {N{1'b0}};
            cnt_r       <= {N{1'b0}};
            cpu_reset_r <= BOOT_HOLD;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ld_start) begin
                        addr_r      <= ld_base;
                        cnt_r       <= ld_len;
                        cpu_reset_r <= 1'b1;
                    end else begin
                        addr_r      <= addr_r;
                        cnt_r       <= cnt_r;
                        cpu_reset_r <= cpu_reset_r;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        addr_r <= addr_r + ONE_C;
                        cnt_r  <= cnt_r - ONE_C;
                    end else begin
                        addr_r <= addr_r;
                        cnt_r  <= cnt_r;
                    end
                end
                ST_DONE: cpu_reset_r <= 1'b0;
                default: cpu_reset_r <= cpu_reset_r;
            endcase
        end
    end

    // Array write; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (wr_en_s) mem_r[wr_addr_s] <= wr_data_s;
    end

`ifdef W450_MEM_WR_BYPASS_EN
    assign mem_rd_data1 = (wr_en_s && (wr_addr_s == mem_rd_addr1)) ? wr_data_s : mem_r[mem_rd_addr1];
    assign mem_rd_data2 = (wr_en_s && (wr_addr_s == mem_rd_addr2)) ? wr_data_s : mem_r[mem_rd_addr2];
`else
    assign mem_rd_data1 = mem_r[mem_rd_addr1];
    assign mem_rd_data2 = mem_r[mem_rd_addr2];
`endif

    assign ld_ready  = (state_r == ST_LOAD);
    assign ld_busy   = (state_r == ST_LOAD) || (state_r == ST_DONE);
    assign ld_done   = (state_r == ST_DONE);
    assign cpu_reset = cpu_reset_r;

endmodule
